// File: rtl/vdp_g1_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_g1_fetch_pkg
//  Description : Shared constants, FSM state encodings and the tile colour
//                resolve helper for the Graphics I scan-line fetch engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package vdp_g1_fetch_pkg;

   // Screen geometry
   localparam logic [7:0] SCREEN_ROWS   = 8'd192;
   localparam int         TILES_PER_ROW = 32;
   localparam logic [4:0] LAST_TILE     = 5'(TILES_PER_ROW - 1);

   // Register base field widths (R2 name, R3 color, R4 pattern)
   localparam int NAME_BASE_W  = 4;
   localparam int COLOR_BASE_W = 8;
   localparam int PAT_BASE_W   = 3;

   // Fetch FSM state encodings
   typedef logic [2:0] fetch_state_t;
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_NAME_I = 3'd1;
   localparam logic [2:0] S_NAME_C = 3'd2;
   localparam logic [2:0] S_PAT_I  = 3'd3;
   localparam logic [2:0] S_PAT_C  = 3'd4;
   localparam logic [2:0] S_COL_I  = 3'd5;
   localparam logic [2:0] S_COL_C  = 3'd6;

   // Expand one pattern byte into eight 4-bit colours, leftmost pixel in the
   // top nibble. Transparent (0) colours fall through to the backdrop.
   function automatic logic [31:0] resolve_tile(input logic [7:0] pat,
                                                input logic [7:0] color,
                                                input logic [3:0] bd);
      logic [31:0] word;
      logic [3:0]  c;
      word = '0;
      for (int i = 0; i < 8; i++) begin
         c = pat[7 - i] ? color[7:4] : color[3:0];
         if (c == 4'd0) begin
            c = bd;
         end
         word[31 - 4*i -: 4] = c;
      end
      return word;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vdp_g1_fetch_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_g1_fetch_line_buf
//  Description : Ping-pong line buffer, 2 banks x 32 words x 32 bits.
//                One write port, one registered read port (EBR friendly).
//  Revision    : 1.0 - initial release
// ============================================================================
module vdp_g1_fetch_line_buf (
   input  logic        clk,
   input  logic        we_i,
   input  logic        wbank_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic        rbank_i,
   input  logic [4:0]  raddr_i,
   output logic [31:0] rdata_o
);

   logic [31:0] mem_q [0:63];
   logic [31:0] rdata_q;

   // Synchronous write and registered read; no reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[{wbank_i, waddr_i}] <= wdata_i;
      end
      rdata_q <= mem_q[{rbank_i, raddr_i}];
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vdp_g1_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_g1_fetch
//  Description : Graphics I scan-line fetch engine. Reads name, pattern and
//                color bytes for 32 tiles over the VRAM DMA port, resolves
//                256 pixels to 4-bit colours into a ping-pong line buffer and
//                serves the display side from the other bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module vdp_g1_fetch
   import vdp_g1_fetch_pkg::*;
#(
   parameter int VRAM_SIZE = 8192,
   parameter int AW        = $clog2(VRAM_SIZE)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    line_go,
   input  logic [7:0]              line_row,
   input  logic                    enable,
   input  logic [NAME_BASE_W-1:0]  reg_name,
   input  logic [COLOR_BASE_W-1:0] reg_color,
   input  logic [PAT_BASE_W-1:0]   reg_pattern,
   input  logic [3:0]              backdrop,
   output logic [AW-1:0]           dma_addr,
   output logic                    dma_rd_tick,
   input  logic [7:0]              vram_dout,
   output logic                    busy,
   input  logic                    pix_swap,
   input  logic [7:0]              pix_x,
   output logic [3:0]              pix_color,
   output logic                    overrun
);

   // Fetch state
   logic [2:0]      state_q, state_d;
   logic [4:0]      col_q, col_d;
   logic [7:0]      row_q, row_d;
   logic [4:0]      name_hi_q, name_hi_d;   // only name[7:3] is needed after PAT_I
   logic [7:0]      pat_q, pat_d;

   // Bank bookkeeping
   logic            disp_sel_q, disp_sel_d;
   logic [1:0]      blank_q, blank_d;
   logic [1:0][3:0] bd_q, bd_d;

   // DMA / status outputs
   logic [AW-1:0]   dma_addr_q, dma_addr_d;
   logic            dma_rd_tick_q, dma_rd_tick_d;
   logic            overrun_q, overrun_d;

   // Display pipeline
   logic            show_blank_q;
   logic [3:0]      show_bd_q;
   logic [2:0]      show_sub_q;

   // Combinational helpers
   logic            w_busy, w_abort, w_accept, w_fetch, w_wbank;
   logic [4:0]      w_col_inc;
   logic [AW-1:0]   w_name_start, w_name_next, w_pat_addr, w_col_addr;
   logic            w_buf_we;
   logic [31:0]     w_buf_wdata, w_buf_rdata, w_shifted;

   assign w_busy    = (state_q != S_IDLE);
   assign w_abort   = pix_swap & w_busy;
   // A swap that aborts a fetch frees the engine for a same-cycle line_go
   assign w_accept  = line_go & (~w_busy | pix_swap);
   assign w_fetch   = w_accept & enable & (line_row < SCREEN_ROWS);
   assign w_wbank   = ~disp_sel_d;
   assign w_col_inc = col_q + 5'd1;

   // VRAM addresses: concatenate fields, keep the low AW bits
   assign w_name_start = AW'({reg_name, line_row[7:3], 5'd0});
   assign w_name_next  = AW'({reg_name, row_q[7:3], w_col_inc});
   assign w_pat_addr   = AW'({reg_pattern, vram_dout, row_q[2:0]});
   assign w_col_addr   = AW'({reg_color, name_hi_q});

   // Tile word: pattern captured in PAT_C, color byte arriving in COL_C
   assign w_buf_wdata = resolve_tile(pat_q, vram_dout, bd_q[~disp_sel_q]);

   // Next-state logic: tile read sequence, then swap abort, then line start
   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      row_d         = row_q;
      name_hi_d     = name_hi_q;
      pat_d         = pat_q;
      disp_sel_d    = disp_sel_q ^ pix_swap;
      blank_d       = blank_q;
      bd_d          = bd_q;
      dma_addr_d    = dma_addr_q;
      dma_rd_tick_d = 1'b0;
      overrun_d     = w_abort;
      w_buf_we      = 1'b0;

      case (state_q)
         S_NAME_I: state_d = S_NAME_C;
         S_NAME_C: begin
            name_hi_d     = vram_dout[7:3];
            dma_addr_d    = w_pat_addr;
            dma_rd_tick_d = 1'b1;
            state_d       = S_PAT_I;
         end
         S_PAT_I:  state_d = S_PAT_C;
         S_PAT_C: begin
            pat_d         = vram_dout;
            dma_addr_d    = w_col_addr;
            dma_rd_tick_d = 1'b1;
            state_d       = S_COL_I;
         end
         S_COL_I:  state_d = S_COL_C;
         S_COL_C: begin
            w_buf_we = 1'b1;
            if (col_q == LAST_TILE) begin
               state_d = S_IDLE;
            end else begin
               col_d         = w_col_inc;
               dma_addr_d    = w_name_next;
               dma_rd_tick_d = 1'b1;
               state_d       = S_NAME_I;
            end
         end
         default:  state_d = S_IDLE;
      endcase

      // Swap during a fetch: drop it and show the half-built bank as backdrop
      if (w_abort) begin
         state_d              = S_IDLE;
         dma_rd_tick_d        = 1'b0;
         w_buf_we             = 1'b0;
         blank_d[~disp_sel_q] = 1'b1;
      end

      // Line start targets the bank not being displayed after any swap
      if (w_accept) begin
         row_d          = line_row;
         bd_d[w_wbank]  = backdrop;
         if (w_fetch) begin
            blank_d[w_wbank] = 1'b0;
            col_d            = 5'd0;
            dma_addr_d       = w_name_start;
            dma_rd_tick_d    = 1'b1;
            state_d          = S_NAME_I;
         end else begin
            blank_d[w_wbank] = 1'b1;
         end
      end
   end

   // Fetch engine and bank state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         col_q         <= 5'd0;
         row_q         <= 8'd0;
         name_hi_q     <= 5'd0;
         pat_q         <= 8'd0;
         disp_sel_q    <= 1'b0;
         blank_q       <= 2'b11;
         bd_q          <= '0;
         dma_addr_q    <= '0;
         dma_rd_tick_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         row_q         <= row_d;
         name_hi_q     <= name_hi_d;
         pat_q         <= pat_d;
         disp_sel_q    <= disp_sel_d;
         blank_q       <= blank_d;
         bd_q          <= bd_d;
         dma_addr_q    <= dma_addr_d;
         dma_rd_tick_q <= dma_rd_tick_d;
         overrun_q     <= overrun_d;
      end
   end

   // Display-side selects, aligned with the buffer's registered read
   always_ff @(posedge clk) begin
      if (reset) begin
         show_blank_q <= 1'b1;
         show_bd_q    <= 4'd0;
         show_sub_q   <= 3'd0;
      end else begin
         show_blank_q <= blank_q[disp_sel_q];
         show_bd_q    <= bd_q[disp_sel_q];
         show_sub_q   <= pix_x[2:0];
      end
   end

   vdp_g1_fetch_line_buf u_line_buf (
      .clk     (clk),
      .we_i    (w_buf_we),
      .wbank_i (~disp_sel_q),
      .waddr_i (col_q),
      .wdata_i (w_buf_wdata),
      .rbank_i (disp_sel_q),
      .raddr_i (pix_x[7:3]),
      .rdata_o (w_buf_rdata)
   );

   // Pick the pixel nibble out of the fetched word (pixel 0 in the top nibble)
   assign w_shifted = w_buf_rdata << {show_sub_q, 2'b00};

   assign pix_color   = show_blank_q ? show_bd_q : w_shifted[31:28];
   assign dma_addr    = dma_addr_q;
   assign dma_rd_tick = dma_rd_tick_q;
   assign busy        = w_busy;
   assign overrun     = overrun_q;

endmodule
`default_nettype wire
